// File: rtl/dec_pkg.sv
// Shared definitions for the SEC-DED decoder: width codes, NOF encodings and
// the parity-check matrix column generator used by the syndrome stage.
package dec_pkg;

  localparam logic [1:0] WIDTH_SMALL  = 2'b00;
  localparam logic [1:0] WIDTH_MEDIUM = 2'b01;
  localparam logic [1:0] WIDTH_LARGE  = 2'b10;

  localparam logic [1:0] NOF_NONE   = 2'b00;
  localparam logic [1:0] NOF_SINGLE = 2'b01;
  localparam logic [1:0] NOF_DOUBLE = 2'b10;

  localparam int K_SMALL  = 3;
  localparam int K_MEDIUM = 4;
  localparam int K_LARGE  = 5;

  // Widest H column (large mode).
  localparam int H_WIDTH = 5;

  // Code 11 is reserved and behaves as large.
  function automatic logic [1:0] norm_width(input logic [1:0] code);
    return (code == WIDTH_SMALL || code == WIDTH_MEDIUM) ? code : WIDTH_LARGE;
  endfunction

  function automatic int check_bits(input logic [1:0] mode);
    int k;
    case (mode)
      WIDTH_SMALL:  k = K_SMALL;
      WIDTH_MEDIUM: k = K_MEDIUM;
      default:      k = K_LARGE;
    endcase
    return k;
  endfunction

  function automatic int active_bits(input logic [1:0] mode);
    int n;
    case (mode)
      WIDTH_SMALL:  n = 8;
      WIDTH_MEDIUM: n = 16;
      default:      n = 32;
    endcase
    return n;
  endfunction

  // Check bits sit at the bottom with unit columns, the overall parity bit
  // has an all-zero column, and data bits take the remaining non-zero,
  // non-power-of-two values in ascending order.
  function automatic logic [H_WIDTH-1:0] h_col(input int idx, input logic [1:0] mode);
    int k;
    int n;
    int cnt;
    logic [H_WIDTH-1:0] col;
    k   = check_bits(mode);
    n   = idx - k;
    cnt = 0;
    col = '0;
    if (idx >= active_bits(mode)) begin
      col = '0;
    end else if (idx < k) begin
      col = H_WIDTH'(1) << idx;
    end else if (idx > k) begin
      for (int v = 1; v < 32; v++) begin
        if (v < (1 << k) && (v & (v - 1)) != 0) begin
          cnt++;
          if (cnt == n) col = H_WIDTH'(v);
        end
      end
    end
    return col;
  endfunction

endpackage

// File: rtl/syndrome_xor.sv
// Combinational syndrome and overall-parity generator over a masked codeword.
module syndrome_xor
  import dec_pkg::*;
#(
  parameter int AMBA_WORD = 32,
  parameter int SYN_WIDTH = 5
) (
  input  logic [AMBA_WORD-1:0] code,
  input  logic [1:0]           mode,
  output logic [SYN_WIDTH-1:0] syn,
  output logic                 par
);

  logic [H_WIDTH-1:0] acc;

  always_comb begin
    logic [H_WIDTH-1:0] col;
    acc = '0;
    par = 1'b0;
    col = '0;
    for (int j = 0; j < AMBA_WORD; j++) begin
      // Constant-argument calls so each column folds to a fixed value per mode.
      if (mode == WIDTH_SMALL) begin
        col = h_col(j, WIDTH_SMALL);
      end else if (mode == WIDTH_MEDIUM) begin
        col = h_col(j, WIDTH_MEDIUM);
      end else begin
        col = h_col(j, WIDTH_LARGE);
      end
      if (code[j]) begin
        acc = acc ^ col;
        par = ~par;
      end
    end
  end

  assign syn = SYN_WIDTH'(acc);

endmodule

// File: rtl/syndrome_calc.sv
// Syndrome stage of the SEC-DED decoder: capture, compute S/NOF, present for
// one cycle, and keep saturating correctable/uncorrectable event counters.
module syndrome_calc
  import dec_pkg::*;
#(
  parameter int AMBA_WORD = 32,
  parameter int SYN_WIDTH = 5,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           codeword_width,
  input  logic [AMBA_WORD-1:0] data_in,
  input  logic                 cnt_clr,
  output logic [SYN_WIDTH-1:0] S,
  output logic [1:0]           NOF,
  output logic                 Small,
  output logic                 Medium,
  output logic [AMBA_WORD-1:0] data_out,
  output logic                 out_valid,
  output logic [CNT_WIDTH-1:0] corr_cnt,
  output logic [CNT_WIDTH-1:0] uncorr_cnt,
  output logic [1:0]           state_dbg
);

  // Handshake: a codeword transfers on a rising edge where in_valid and
  // in_ready are both high; out_valid is a single-cycle strobe with no back-pressure.

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]           state_q,  state_d;
  logic [AMBA_WORD-1:0] code_q,   code_d;
  logic [1:0]           mode_q,   mode_d;
  logic [SYN_WIDTH-1:0] s_q,      s_d;
  logic [1:0]           nof_q,    nof_d;
  logic                 small_q,  small_d;
  logic                 medium_q, medium_d;
  logic [AMBA_WORD-1:0] dout_q,   dout_d;
  logic [CNT_WIDTH-1:0] corr_q,   corr_d;
  logic [CNT_WIDTH-1:0] uncorr_q, uncorr_d;

  logic [1:0]           mode_in;
  logic [AMBA_WORD-1:0] mask_in;
  logic [SYN_WIDTH-1:0] syn_w;
  logic                 par_w;
  logic [1:0]           nof_w;

  syndrome_xor #(
    .AMBA_WORD (AMBA_WORD),
    .SYN_WIDTH (SYN_WIDTH)
  ) u_syndrome_xor (
    .code (code_q),
    .mode (mode_q),
    .syn  (syn_w),
    .par  (par_w)
  );

  always_comb begin
    mode_in = norm_width(codeword_width);
    mask_in = '0;
    for (int j = 0; j < AMBA_WORD; j++) begin
      if (j < active_bits(mode_in)) mask_in[j] = 1'b1;
    end
  end

  // Odd parity means exactly one flip (possibly the parity bit itself).
  always_comb begin
    if (par_w) begin
      nof_w = NOF_SINGLE;
    end else if (syn_w != '0) begin
      nof_w = NOF_DOUBLE;
    end else begin
      nof_w = NOF_NONE;
    end
  end

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    mode_d   = mode_q;
    s_d      = s_q;
    nof_d    = nof_q;
    small_d  = small_q;
    medium_d = medium_q;
    dout_d   = dout_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          code_d  = data_in & mask_in;
          mode_d  = mode_in;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        s_d      = syn_w;
        nof_d    = nof_w;
        small_d  = (mode_q == WIDTH_SMALL);
        medium_d = (mode_q == WIDTH_MEDIUM);
        dout_d   = code_q;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Clear wins over an increment landing in the same cycle.
  always_comb begin
    corr_d   = corr_q;
    uncorr_d = uncorr_q;
    if (cnt_clr) begin
      corr_d   = '0;
      uncorr_d = '0;
    end else if (state_q == ST_DONE) begin
      if (nof_q == NOF_SINGLE && corr_q != '1) corr_d = corr_q + CNT_WIDTH'(1);
      if (nof_q == NOF_DOUBLE && uncorr_q != '1) uncorr_d = uncorr_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      code_q   <= '0;
      mode_q   <= WIDTH_SMALL;
      s_q      <= '0;
      nof_q    <= NOF_NONE;
      small_q  <= 1'b0;
      medium_q <= 1'b0;
      dout_q   <= '0;
      corr_q   <= '0;
      uncorr_q <= '0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      mode_q   <= mode_d;
      s_q      <= s_d;
      nof_q    <= nof_d;
      small_q  <= small_d;
      medium_q <= medium_d;
      dout_q   <= dout_d;
      corr_q   <= corr_d;
      uncorr_q <= uncorr_d;
    end
  end

  assign in_ready   = rst && (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign S          = s_q;
  assign NOF        = nof_q;
  assign Small      = small_q;
  assign Medium     = medium_q;
  assign data_out   = dout_q;
  assign corr_cnt   = corr_q;
  assign uncorr_cnt = uncorr_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_syndrome_calc.sv
// Directed bench for syndrome_calc: vector table plus handshake, saturation,
// clear-priority and mid-transaction reset sequences.
module tb_syndrome_calc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  codeword_width = 2'b10;
  logic [31:0] data_in = '0;
  logic        cnt_clr = 1'b0;

  logic        in_ready, out_valid, Small, Medium;
  logic [4:0]  S;
  logic [1:0]  NOF, state_dbg;
  logic [31:0] data_out;
  logic [15:0] corr_cnt, uncorr_cnt;

  // Second instance with narrow counters so saturation is reachable quickly.
  logic        s_in_ready, s_out_valid, s_small, s_medium;
  logic [4:0]  s_s;
  logic [1:0]  s_nof, s_state_dbg;
  logic [31:0] s_data_out;
  logic [3:0]  s_corr_cnt, s_uncorr_cnt;

  int total = 0;
  int bad = 0;
  int exp_corr = 0;
  int exp_uncorr = 0;

  typedef struct {
    logic [1:0]  width;
    logic [31:0] data;
    logic [4:0]  s;
    logic [1:0]  nof;
    logic [31:0] dout;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  syndrome_calc dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .codeword_width(codeword_width), .data_in(data_in), .cnt_clr(cnt_clr),
    .S(S), .NOF(NOF), .Small(Small), .Medium(Medium), .data_out(data_out),
    .out_valid(out_valid), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt),
    .state_dbg(state_dbg)
  );

  syndrome_calc #(.CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .codeword_width(codeword_width), .data_in(data_in), .cnt_clr(cnt_clr),
    .S(s_s), .NOF(s_nof), .Small(s_small), .Medium(s_medium), .data_out(s_data_out),
    .out_valid(s_out_valid), .corr_cnt(s_corr_cnt), .uncorr_cnt(s_uncorr_cnt),
    .state_dbg(s_state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sat15(input int x);
    return (x > 15) ? 15 : x;
  endfunction

  task automatic check_counters(input string tag);
    check({tag, "_corr"}, corr_cnt, exp_corr);
    check({tag, "_uncorr"}, uncorr_cnt, exp_uncorr);
    check({tag, "_sat_corr"}, s_corr_cnt, sat15(exp_corr));
    check({tag, "_sat_uncorr"}, s_uncorr_cnt, sat15(exp_uncorr));
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_wait", in_ready, 1'b1);
  endtask

  // Full transaction: accept, strobe cycle checks, then counter checks.
  task automatic do_txn(input vec_t v, input string tag);
    wait_ready();
    codeword_width = v.width;
    data_in = v.data;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_calc_no_valid"}, out_valid, 1'b0);
    @(posedge clk); #1;
    check({tag, "_out_valid"}, out_valid, 1'b1);
    check({tag, "_S"}, S, v.s);
    check({tag, "_NOF"}, NOF, v.nof);
    check({tag, "_Small"}, Small, v.width == 2'b00);
    check({tag, "_Medium"}, Medium, v.width == 2'b01);
    check({tag, "_data_out"}, data_out, v.dout);
    if (v.nof == 2'b01) exp_corr++;
    else if (v.nof == 2'b10) exp_uncorr++;
    @(posedge clk); #1;
    check({tag, "_valid_drop"}, out_valid, 1'b0);
    check_counters(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vecs[0]  = '{2'b10, 32'h0000_0000, 5'h00, 2'b00, 32'h0000_0000};
    vecs[1]  = '{2'b10, 32'h0000_0040, 5'h03, 2'b01, 32'h0000_0040};
    vecs[2]  = '{2'b10, 32'h8000_0000, 5'h1F, 2'b01, 32'h8000_0000};
    vecs[3]  = '{2'b10, 32'h0000_0020, 5'h00, 2'b01, 32'h0000_0020};
    vecs[4]  = '{2'b10, 32'h0000_0003, 5'h03, 2'b10, 32'h0000_0003};
    vecs[5]  = '{2'b00, 32'hFFFF_FF10, 5'h03, 2'b01, 32'h0000_0010};
    vecs[6]  = '{2'b01, 32'h0000_0020, 5'h03, 2'b01, 32'h0000_0020};
    vecs[7]  = '{2'b11, 32'h0000_0001, 5'h01, 2'b01, 32'h0000_0001};
    vecs[8]  = '{2'b01, 32'hFFFF_0003, 5'h03, 2'b10, 32'h0000_0003};
    vecs[9]  = '{2'b00, 32'h0000_00FF, 5'h00, 2'b00, 32'h0000_00FF};
    vecs[10] = '{2'b10, 32'h0000_0140, 5'h05, 2'b10, 32'h0000_0140};
    vecs[11] = '{2'b01, 32'h0000_8000, 5'h0F, 2'b01, 32'h0000_8000};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_state", state_dbg, 2'd0);
    check("rst_S", S, 5'h00);
    check("rst_NOF", NOF, 2'b00);
    check("rst_data_out", data_out, 32'h0);
    check_counters("rst");
    rst = 1'b1;
    @(posedge clk); #1;
    check("idle_ready", in_ready, 1'b1);

    for (int i = 0; i < 12; i++) begin
      do_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Outputs hold after the strobe
    repeat (3) @(posedge clk);
    #1;
    check("hold_S", S, 5'h0F);
    check("hold_NOF", NOF, 2'b01);
    check("hold_Medium", Medium, 1'b1);
    check("hold_data_out", data_out, 32'h0000_8000);
    check("hold_no_valid", out_valid, 1'b0);

    // Continuous in_valid: one accept and one strobe every third cycle
    codeword_width = 2'b10;
    data_in = 32'h0000_0040;
    in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      check($sformatf("stream_ready%0d", i), in_ready, (i % 3) == 0);
      check($sformatf("stream_valid%0d", i), out_valid, (i % 3) == 2);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    exp_corr += 4;
    check_counters("stream");

    // Reset during CALC aborts the transaction
    wait_ready();
    codeword_width = 2'b10;
    data_in = 32'h0000_0003;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("abort_in_calc", state_dbg, 2'd1);
    rst = 1'b0;
    #1;
    exp_corr = 0;
    exp_uncorr = 0;
    check("abort_state", state_dbg, 2'd0);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_in_ready", in_ready, 1'b0);
    check("abort_S", S, 5'h00);
    check("abort_NOF", NOF, 2'b00);
    check("abort_Small", Small, 1'b0);
    check("abort_Medium", Medium, 1'b0);
    check("abort_data_out", data_out, 32'h0);
    check_counters("abort");
    repeat (2) @(posedge clk);
    #1;
    check("abort_hold_valid", out_valid, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_valid", out_valid, 1'b0);
    check("post_rst_state", state_dbg, 2'd0);
    v = '{2'b10, 32'h0000_0003, 5'h03, 2'b10, 32'h0000_0003};
    do_txn(v, "post_rst");

    // Clear, then drive both counter flavours past the narrow instance's limit
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    exp_corr = 0;
    exp_uncorr = 0;
    check_counters("clr");
    v = '{2'b10, 32'h0000_0040, 5'h03, 2'b01, 32'h0000_0040};
    for (int i = 0; i < 17; i++) do_txn(v, $sformatf("satc%0d", i));
    v = '{2'b10, 32'h0000_0003, 5'h03, 2'b10, 32'h0000_0003};
    for (int i = 0; i < 16; i++) do_txn(v, $sformatf("satu%0d", i));

    // Clear coinciding with an increment
    wait_ready();
    codeword_width = 2'b10;
    data_in = 32'h0000_0040;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("clr_inc_valid", out_valid, 1'b1);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    exp_corr = 0;
    exp_uncorr = 0;
    check_counters("clr_inc");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
